clk_mon_ctrl: RTL and testbench
===============================

Name: clk_mon_ctrl

Overview:
- Measurement sequencer for the clock-monitor outputs that sysctrl routes to mprj_io[14] (core clock) and mprj_io[15] (user clock).
- Opens a timed gate window of programmable length on one or both monitor channels and enables the selected pad output only inside that window.
- Counts rising edges of the monitored clock inside the window and reports per-channel counts plus completion status.
- Sits between the sysctrl register block and the GPIO pad output-enable path.

Parameters:
WINDOW_W, 16, width of the window-length input, in reference-clock cycles
CNT_W, 16, width of each edge counter
SYNC_STAGES, 2, synchronizer depth on each mon_in bit (minimum 2)

Ports:
clock  input  1  reference clock; all state is in this domain
resetb  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin a measurement; ignored while busy
mode  input  2  00 = channel 0 only, 01 = channel 1 only, 10 = ch0 then ch1, 11 = illegal
window  input  WINDOW_W  gate length in clock cycles; latched on an accepted start
mon_in  input  2  monitored clocks, asynchronous (bit0 = core clk, bit1 = user clk)
mon_oe  output  2  pad output enable per channel; high only while that channel is gating
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse when the measurement completes
count0  output  CNT_W  edge count for channel 0
count1  output  CNT_W  edge count for channel 1
sat  output  2  sticky per-channel saturation flag for the current measurement
err  output  1  high one cycle after a start with mode==11

Behaviour:
- Reset values: mon_oe=0, busy=0, done=0, count0=0, count1=0, sat=0, err=0. FSM=IDLE. Synchronizer and previous-sample flops are cleared to 0.
- Edge detection:
  - mon_in[i] passes through SYNC_STAGES flops; prev[i] always tracks the last synchronized value.
  - edge[i] = sync[i] & ~prev[i].
  - Valid for mon_in frequency below clock/2.
- FSM states: IDLE, ARM, GATE, DONE.
- IDLE:
  - start with mode 00/01/10: latch mode and window, set busy, go to ARM.
  - start with mode 11: err pulses on the next cycle, stay in IDLE, counts are untouched.
- ARM (1 cycle):
  - Clear count and sat of the channel about to be gated.
  - Load the down-counter with the latched window.
  - If window==0, go to DONE and leave mon_oe low. Otherwise go to GATE.
- GATE:
  - mon_oe[ch]=1 and the other bit is 0.
  - Each cycle: count[ch] += edge[ch]; down-counter decrements.
  - Exit after exactly window cycles in GATE.
  - Mode 10 on ch0 exit: go back to ARM with ch=1 (one gap cycle, mon_oe=00), then gate ch1.
  - All other exits: go to DONE.
- DONE (1 cycle): done=1, busy drops to 0 in the same cycle, return to IDLE.
- Latency, single channel, window=N>0:
  - start at cycle T, ARM at T+1, GATE at T+2..T+N+1, done at T+N+2.
  - Mode 10: done at T+2N+3.
- Counter saturates at all-ones: further edges do not wrap, and sat[ch] is set.
- Untouched channel: in single-channel modes the other channel's count and sat hold their previous values.
- start while busy: ignored; no queueing and no err.
- resetb asserted mid-measurement: all outputs return to reset values immediately and asynchronously, and mon_oe drops without waiting for the window to end.
- Edge on the ARM or gap cycle: not counted.

Optional Feature:
CLK_MON_IRQ_EN
- Defined:
  - Adds input irq_clr (1) and output irq (1).
  - irq is set on the done cycle and held until irq_clr is high for one cycle.
  - If irq_clr and done occur in the same cycle, set wins.
  - irq resets to 0.
- Not defined: the ports are absent and behaviour is otherwise identical.

Test Plan:
- mode=00, window=512, mon_in[0] toggling every 2 clocks (period 4), mon_in[1]=0 -> mon_oe=01 for exactly 512 cycles, done at start+514, count0 in {128,129}, count1 unchanged, sat=00.
- mode=01, window=0 -> done at start+2, mon_oe never asserted, count1=0, busy high for exactly 1 cycle.
- mode=10, window=100, mon_in[0] period 4, mon_in[1] period 10 -> mon_oe=01 for 100 cycles, then 1 gap cycle with 00, then 10 for 100 cycles; count0 in {25,26}, count1 in {10,11}, done at start+203.
- CNT_W=4, window=200, mon_in[0] period 4 -> count0=15, sat[0]=1; a following run with slower input clears sat[0].
- start asserted mid-GATE with different mode/window -> ignored and first measurement completes unchanged. Then mode=11 -> err pulse, busy stays 0. Then resetb low mid-GATE -> mon_oe=00, counts 0 immediately.
- With CLK_MON_IRQ_EN: irq rises on done and stays high. irq_clr coincident with the next done keeps irq=1. A lone irq_clr clears it.

Source files
------------

// File: rtl/clk_mon_ctrl.sv
// ============================================================================
// Module      : clk_mon_ctrl
// Description : Clock-monitor measurement sequencer. Opens a programmable gate
//               window on one or both monitor channels (core clock on bit 0,
//               user clock on bit 1), enables the pad output only inside that
//               window, and counts synchronized rising edges of the monitored
//               clock while the window is open.
//               Optional macro CLK_MON_IRQ_EN adds a sticky completion
//               interrupt (irq) with a clear input (irq_clr).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_mon_ctrl #(
    parameter int WINDOW_W    = 16,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clock,
    input  logic                resetb,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic [WINDOW_W-1:0] window,
    input  logic [1:0]          mon_in,
`ifdef CLK_MON_IRQ_EN
    input  logic                irq_clr,
    output logic                irq,
`endif
    output logic [1:0]          mon_oe,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    count0,
    output logic [CNT_W-1:0]    count1,
    output logic [1:0]          sat,
    output logic                err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_GATE = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [1:0] c_MODE_CH1  = 2'b01;
    localparam logic [1:0] c_MODE_BOTH = 2'b10;
    localparam logic [1:0] c_MODE_BAD  = 2'b11;

    localparam logic [CNT_W-1:0]    c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]    c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WINDOW_W-1:0] c_WIN_ONE = {{(WINDOW_W-1){1'b0}}, 1'b1};

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [1:0]          r_sync [SYNC_STAGES];
    logic [1:0]          r_prev;
    logic [1:0]          w_edge;
    logic [1:0]          r_mode;
    logic [WINDOW_W-1:0] r_win;
    logic [WINDOW_W-1:0] r_down;
    logic                r_ch;
    logic [CNT_W-1:0]    r_count0;
    logic [CNT_W-1:0]    r_count1;
    logic [1:0]          r_sat;
    logic                r_err;
    logic                w_accept;
    logic                w_illegal;
    logic                w_last_gate;
    logic [1:0]          w_mon_oe;
    logic                w_busy;
    logic                w_done;

    // Synchronize the asynchronous monitor clocks and keep the previous sample
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= 2'b00;
            end
            r_prev <= 2'b00;
        end else begin
            r_sync[0] <= mon_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_edge      = r_sync[SYNC_STAGES-1] & ~r_prev;
    assign w_accept    = (r_state == S_IDLE) && start && (mode != c_MODE_BAD);
    assign w_illegal   = (r_state == S_IDLE) && start && (mode == c_MODE_BAD);
    assign w_last_gate = (r_down == c_WIN_ONE);

    // State register
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; channel 0 of a dual run returns to ARM for channel 1
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_ARM;
                end
            end
            S_ARM: begin
                w_state_nxt = (r_win == '0) ? S_DONE : S_GATE;
            end
            S_GATE: begin
                if (w_last_gate) begin
                    w_state_nxt = ((r_mode == c_MODE_BOTH) && !r_ch) ? S_ARM : S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from the state: pad enable only while gating
    always_comb begin
        w_mon_oe = 2'b00;
        w_busy   = 1'b0;
        w_done   = 1'b0;
        case (r_state)
            S_ARM: begin
                w_busy = 1'b1;
            end
            S_GATE: begin
                w_busy   = 1'b1;
                w_mon_oe = r_ch ? 2'b10 : 2'b01;
            end
            S_DONE: begin
                w_done = 1'b1;
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    // Measurement datapath: latch request, arm window, count gated edges
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_mode   <= 2'b00;
            r_win    <= '0;
            r_down   <= '0;
            r_ch     <= 1'b0;
            r_count0 <= '0;
            r_count1 <= '0;
            r_sat    <= 2'b00;
            r_err    <= 1'b0;
        end else begin
            r_err <= w_illegal;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mode <= mode;
                        r_win  <= window;
                        r_ch   <= (mode == c_MODE_CH1);
                    end
                end
                S_ARM: begin
                    r_down <= r_win;
                    if (r_ch) begin
                        r_count1 <= '0;
                        r_sat[1] <= 1'b0;
                    end else begin
                        r_count0 <= '0;
                        r_sat[0] <= 1'b0;
                    end
                end
                S_GATE: begin
                    r_down <= r_down - c_WIN_ONE;
                    if (w_state_nxt == S_ARM) begin
                        r_ch <= 1'b1;
                    end
                    // Saturate rather than wrap; a dropped edge marks the channel
                    if (!r_ch && w_edge[0]) begin
                        if (r_count0 == c_CNT_MAX) begin
                            r_sat[0] <= 1'b1;
                        end else begin
                            r_count0 <= r_count0 + c_CNT_ONE;
                        end
                    end
                    if (r_ch && w_edge[1]) begin
                        if (r_count1 == c_CNT_MAX) begin
                            r_sat[1] <= 1'b1;
                        end else begin
                            r_count1 <= r_count1 + c_CNT_ONE;
                        end
                    end
                end
                default: begin
                    r_ch <= r_ch;
                end
            endcase
        end
    end

`ifdef CLK_MON_IRQ_EN
    logic r_irq;

    // Sticky interrupt; a completion in the same cycle as a clear keeps it set
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_irq <= 1'b0;
        end else if (w_done) begin
            r_irq <= 1'b1;
        end else if (irq_clr) begin
            r_irq <= 1'b0;
        end
    end

    assign irq = r_irq | w_done;
`endif

    assign mon_oe = w_mon_oe;
    assign busy   = w_busy;
    assign done   = w_done;
    assign count0 = r_count0;
    assign count1 = r_count1;
    assign sat    = r_sat;
    assign err    = r_err;

endmodule

`default_nettype wire

// File: tb/tb_clk_mon_ctrl.sv
// ============================================================================
// Module      : tb_clk_mon_ctrl
// Description : Self-checking bench for clk_mon_ctrl. Two instances (16-bit
//               and 4-bit counters) share one stimulus; a timeline model
//               predicts busy/done/mon_oe/err each cycle and the permitted
//               edge-count range for each channel.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_clk_mon_ctrl;

    localparam int c_MAX  = 65535;
    localparam int c_MAX4 = 15;

    logic        clock  = 1'b0;
    logic        resetb = 1'b1;
    logic        start  = 1'b0;
    logic [1:0]  mode   = 2'b00;
    logic [15:0] window = 16'd0;
    logic [1:0]  mon_in = 2'b00;

    logic [1:0]  mon_oe, sat, mon_oe4, sat4;
    logic        busy, done, err, busy4, done4, err4;
    logic [15:0] count0, count1;
    logic [3:0]  count0_4, count1_4;
`ifdef CLK_MON_IRQ_EN
    logic        irq_clr = 1'b0;
    logic        irq, irq4;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit cmp_en = 0;

    int half[2] = '{0, 0};
    int ph[2]   = '{0, 0};

    // model state
    bit       m_act = 0;
    int       m_k = 0;
    int       m_N = 0;
    int       m_last = 0;
    logic [1:0] m_mode = 2'b00;
    bit       m_err = 0;
    int       m_lo[2] = '{0, 0};
    int       m_hi[2] = '{0, 0};

    clk_mon_ctrl u_dut (
        .clock(clock), .resetb(resetb), .start(start), .mode(mode),
        .window(window), .mon_in(mon_in),
`ifdef CLK_MON_IRQ_EN
        .irq_clr(irq_clr), .irq(irq),
`endif
        .mon_oe(mon_oe), .busy(busy), .done(done), .count0(count0),
        .count1(count1), .sat(sat), .err(err)
    );

    clk_mon_ctrl #(.WINDOW_W(16), .CNT_W(4), .SYNC_STAGES(2)) u_dut4 (
        .clock(clock), .resetb(resetb), .start(start), .mode(mode),
        .window(window), .mon_in(mon_in),
`ifdef CLK_MON_IRQ_EN
        .irq_clr(irq_clr), .irq(irq4),
`endif
        .mon_oe(mon_oe4), .busy(busy4), .done(done4), .count0(count0_4),
        .count1(count1_4), .sat(sat4), .err(err4)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d..%0d (t=%0t)", nm, act, lo, hi, $time);
        end
    endtask

    // Count and sat check against a counter of maximum mx
    task automatic chk_cnt(input string nm, input int act, input int sat_act,
                           input int lo, input int hi, input int mx);
        if (lo > mx) begin
            chk({nm, "_cnt"}, act, mx);
            chk({nm, "_sat"}, sat_act, 1);
        end else begin
            chk_rng({nm, "_cnt"}, act, lo, (hi > mx) ? mx : hi);
            if (hi <= mx) chk({nm, "_sat"}, sat_act, 0);
        end
    endtask

    // Monitored clocks: square waves of period 2*half, changed on negedge
    initial forever begin
        @(negedge clock);
        for (int i = 0; i < 2; i++) begin
            if (half[i] == 0) begin
                mon_in[i] = 1'b0;
                ph[i] = 0;
            end else begin
                ph[i]++;
                if (ph[i] >= half[i]) begin
                    ph[i] = 0;
                    mon_in[i] = ~mon_in[i];
                end
            end
        end
    end

    function automatic void set_rng(input int ch);
        if (m_N == 0 || half[ch] == 0) begin
            m_lo[ch] = 0;
            m_hi[ch] = 0;
        end else begin
            m_lo[ch] = m_N / (2 * half[ch]);
            m_hi[ch] = m_lo[ch] + 1;
        end
    endfunction

    // Model: k counts cycles since an accepted start (k=0 is the arm cycle)
    initial forever begin
        bit was_idle;
        @(posedge clock);
        cyc++;
        if (resetb) begin
            was_idle = !m_act;
            if (m_act) begin
                m_k++;
                if (m_k > m_last) m_act = 0;
            end
            m_err = 0;
            if (was_idle && start) begin
                if (mode == 2'b11) begin
                    m_err = 1;
                end else begin
                    m_act  = 1;
                    m_k    = 0;
                    m_mode = mode;
                    m_N    = int'(window);
                    set_rng((mode == 2'b01) ? 1 : 0);
                    if (mode == 2'b10 && m_N > 0) set_rng(1);
                    m_last = (m_N == 0) ? 1 : ((mode == 2'b10) ? 2 * m_N + 2 : m_N + 1);
                end
            end
        end
    end

    initial forever begin
        @(negedge resetb);
        m_act = 0;
        m_err = 0;
        m_lo = '{0, 0};
        m_hi = '{0, 0};
    end

    // Per-cycle comparison of both instances against the model
    initial forever begin
        int exp_busy, exp_done;
        logic [1:0] exp_oe;
        @(negedge clock);
        if (cmp_en && resetb) begin
            exp_busy = (m_act && m_k < m_last) ? 1 : 0;
            exp_done = (m_act && m_k == m_last) ? 1 : 0;
            exp_oe = 2'b00;
            if (m_act && m_N > 0) begin
                if (m_k >= 1 && m_k <= m_N)
                    exp_oe = (m_mode == 2'b01) ? 2'b10 : 2'b01;
                else if (m_mode == 2'b10 && m_k >= m_N + 2 && m_k <= 2 * m_N + 1)
                    exp_oe = 2'b10;
            end
            chk("busy", int'(busy), exp_busy);
            chk("done", int'(done), exp_done);
            chk("mon_oe", int'(mon_oe), int'(exp_oe));
            chk("err", int'(err), int'(m_err));
            chk("busy4", int'(busy4), exp_busy);
            chk("done4", int'(done4), exp_done);
            chk("mon_oe4", int'(mon_oe4), int'(exp_oe));
            chk("err4", int'(err4), int'(m_err));
            if (!m_act || exp_done == 1) begin
                chk_cnt("ch0", int'(count0), int'(sat[0]), m_lo[0], m_hi[0], c_MAX);
                chk_cnt("ch1", int'(count1), int'(sat[1]), m_lo[1], m_hi[1], c_MAX);
                chk_cnt("ch0_4", int'(count0_4), int'(sat4[0]), m_lo[0], m_hi[0], c_MAX4);
                chk_cnt("ch1_4", int'(count1_4), int'(sat4[1]), m_lo[1], m_hi[1], c_MAX4);
            end
        end
    end

    task automatic start_meas(input logic [1:0] md, input int w, output int t0);
        @(negedge clock);
        start  = 1'b1;
        mode   = md;
        window = w[15:0];
        @(posedge clock);
        #1;
        t0    = cyc - 1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input int inj, input bit clr_on_done,
                             output int t_done, output int n01, output int n10,
                             output int nbusy);
        n01 = 0; n10 = 0; nbusy = 0; t_done = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (start) start = 1'b0;
            if (i == inj) begin
                start  = 1'b1;
                mode   = 2'b01;
                window = 16'd7;
            end
            if (mon_oe == 2'b01) n01++;
            if (mon_oe == 2'b10) n10++;
            if (busy) nbusy++;
            if (done) begin
                t_done = cyc;
`ifdef CLK_MON_IRQ_EN
                irq_clr = clr_on_done;
`endif
                break;
            end
        end
        if (t_done < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got no done expected done within %0d cycles", budget);
        end
    endtask

    task automatic run(input logic [1:0] md, input int w, input int inj, input bit clr,
                       output int lat, output int n01, output int n10, output int nbusy);
        int t0, td;
        start_meas(md, w, t0);
        wait_done(2 * w + 50, inj, clr, td, n01, n10, nbusy);
        lat = td - t0;
    endtask

    initial begin
        int lat, n01, n10, nb;

        #1 resetb = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        chk("rst_mon_oe", int'(mon_oe), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_count0", int'(count0), 0);
        chk("rst_count1", int'(count1), 0);
        chk("rst_sat", int'(sat), 0);
        chk("rst_err", int'(err), 0);
`ifdef CLK_MON_IRQ_EN
        chk("rst_irq", int'(irq), 0);
`endif
        @(negedge clock);
        resetb = 1'b1;
        cmp_en = 1;
        repeat (4) @(negedge clock);

        // dual-channel run: ch0 period 4, ch1 period 10
        half = '{2, 5};
        repeat (12) @(negedge clock);
        run(2'b10, 100, -1, 1'b0, lat, n01, n10, nb);
        chk("m10_lat", lat, 203);
        chk("m10_oe01", n01, 100);
        chk("m10_oe10", n10, 100);
        chk_rng("m10_count0", int'(count0), 25, 26);
        chk_rng("m10_count1", int'(count1), 10, 11);
        chk("m10_c4_count0", int'(count0_4), 15);
        chk("m10_c4_sat", int'(sat4), 1);

        // channel 0 only, window 512; channel 1 must be held
        half = '{2, 0};
        repeat (12) @(negedge clock);
        run(2'b00, 512, -1, 1'b0, lat, n01, n10, nb);
        chk("m00_lat", lat, 514);
        chk("m00_oe01", n01, 512);
        chk("m00_oe10", n10, 0);
        chk_rng("m00_count0", int'(count0), 128, 129);
        chk_rng("m00_count1_held", int'(count1), 10, 11);
        chk("m00_sat", int'(sat), 0);

        // channel 1 only, zero window
        run(2'b01, 0, -1, 1'b0, lat, n01, n10, nb);
        chk("w0_lat", lat, 2);
        chk("w0_oe", n01 + n10, 0);
        chk("w0_busy_cycles", nb, 1);
        chk("w0_count1", int'(count1), 0);
        chk_rng("w0_count0_held", int'(count0), 128, 129);

        // saturation on the 4-bit instance, then cleared by a slow run
        run(2'b00, 200, -1, 1'b0, lat, n01, n10, nb);
        chk("sat_count0", int'(count0_4), 15);
        chk("sat_flag", int'(sat4[0]), 1);
        half = '{5, 0};
        repeat (12) @(negedge clock);
        run(2'b00, 20, -1, 1'b0, lat, n01, n10, nb);
        chk_rng("unsat_count0", int'(count0_4), 2, 3);
        chk("unsat_flag", int'(sat4[0]), 0);

        // start while busy is ignored
        half = '{2, 0};
        repeat (12) @(negedge clock);
        run(2'b00, 50, 10, 1'b0, lat, n01, n10, nb);
        chk("busy_start_lat", lat, 52);
        chk("busy_start_oe01", n01, 50);
        chk("busy_start_oe10", n10, 0);
        chk_rng("busy_start_count0", int'(count0), 12, 13);

        // illegal mode
        @(negedge clock);
        start = 1'b1;
        mode  = 2'b11;
        @(posedge clock);
        #1 start = 1'b0;
        chk("err_pulse", int'(err), 1);
        chk("err_busy", int'(busy), 0);
        @(posedge clock);
        #1;
        chk("err_clear", int'(err), 0);
        chk_rng("err_count0_held", int'(count0), 12, 13);

`ifdef CLK_MON_IRQ_EN
        run(2'b00, 10, -1, 1'b0, lat, n01, n10, nb);
        chk("irq_on_done", int'(irq), 1);
        repeat (3) @(posedge clock);
        #1 chk("irq_held", int'(irq), 1);
        run(2'b00, 10, -1, 1'b1, lat, n01, n10, nb);
        @(posedge clock);
        #1 irq_clr = 1'b0;
        chk("irq_set_wins", int'(irq), 1);
        @(negedge clock);
        irq_clr = 1'b1;
        @(posedge clock);
        #1 irq_clr = 1'b0;
        chk("irq_cleared", int'(irq), 0);
`endif

        // asynchronous reset in the middle of a gate window
        begin
            int t0;
            start_meas(2'b00, 100, t0);
        end
        repeat (20) @(negedge clock);
        chk("pre_rst_oe", int'(mon_oe), 1);
        #2 resetb = 1'b0;
        #1;
        chk("arst_mon_oe", int'(mon_oe), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_count0", int'(count0), 0);
        chk("arst_count0_4", int'(count0_4), 0);
        chk("arst_sat4", int'(sat4), 0);
        @(negedge clock);
        resetb = 1'b1;
        repeat (5) @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
